stepper_driver: RTL and testbench

Full-step sequencer for the goalie stepper motor, sitting directly downstream of the processor's memory-mapped I/O. It accepts a target position from the CPU and paces one coil step every `STEP_DIV` clocks. It drives the four phase outputs that reach the `JA` header pins and performs limit-switch homing. It reports position, busy, homed and fault status back to the CPU.

---
 rtl/stepper_driver.sv | 190 +++++++++++++++++++
 tb/tb_stepper_driver.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/stepper_driver.sv
// Full-step stepper sequencer with paced moves, limit-switch homing and fault timeout.
// Define STEPPER_HOLD_EN to keep the coils energised (holding torque) while idle and homed.
module stepper_driver #(
  parameter int STEP_DIV       = 100000,
  parameter int POS_W          = 16,
  parameter int HOME_MAX_STEPS = 4096
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             cmd_valid,
  input  logic [POS_W-1:0] cmd_target,
  output logic             cmd_ready,
  input  logic             home_req,
  input  logic             limit_switch,
  output logic [3:0]       coils,
  output logic             enable,
  output logic [POS_W-1:0] position,
  output logic             busy,
  output logic             homed,
  output logic             fault
);

  localparam int TMR_W = $clog2(STEP_DIV);
  localparam int HC_W  = $clog2(HOME_MAX_STEPS + 1);
  localparam logic [TMR_W-1:0] TMR_RELOAD = TMR_W'(STEP_DIV - 1);
  localparam logic [HC_W-1:0]  HC_MAX     = HC_W'(HOME_MAX_STEPS);

`ifdef STEPPER_HOLD_EN
  localparam logic HOLD_EN = 1'b1;
`else
  localparam logic HOLD_EN = 1'b0;
`endif

  typedef enum logic [1:0] {ST_IDLE, ST_MOVING, ST_HOMING, ST_FAULT} state_t;

  function automatic logic [3:0] phase_pattern(input logic [1:0] p);
    case (p)
      2'd0:    phase_pattern = 4'b1100;
      2'd1:    phase_pattern = 4'b0110;
      2'd2:    phase_pattern = 4'b0011;
      default: phase_pattern = 4'b1001;
    endcase
  endfunction

  state_t             state_q, state_d;
  logic [1:0]         ph_q, ph_d;
  logic [POS_W-1:0]   position_q, position_d;
  logic [POS_W-1:0]   target_q, target_d;
  logic [TMR_W-1:0]   timer_q, timer_d;
  logic [HC_W-1:0]    home_cnt_q, home_cnt_d;
  logic               homed_q, homed_d;
  logic               fault_q, fault_d;
  logic               busy_q, busy_d;
  logic               enable_q, enable_d;
  logic [3:0]         coils_q, coils_d;
  logic               lim_meta_q, lim_s_q;
  logic               stepping, tick, accept, drive_en;

  // home_req takes priority over a simultaneous command
  assign cmd_ready = homed_q && ((state_q == ST_IDLE) || (state_q == ST_MOVING)) && !home_req;
  assign accept    = cmd_valid && cmd_ready;

  always_comb begin
    state_d    = state_q;
    ph_d       = ph_q;
    position_d = position_q;
    target_d   = target_q;
    timer_d    = timer_q;
    home_cnt_d = home_cnt_q;
    homed_d    = homed_q;
    fault_d    = fault_q;
    stepping   = (state_q == ST_MOVING) || (state_q == ST_HOMING);
    tick       = stepping && (timer_q == '0);
    if (stepping) begin
      timer_d = tick ? TMR_RELOAD : timer_q - TMR_W'(1);
    end

    case (state_q)
      ST_IDLE: begin
        if (home_req) begin
          state_d    = ST_HOMING;
          timer_d    = TMR_RELOAD;
          home_cnt_d = '0;
          homed_d    = 1'b0;
          fault_d    = 1'b0;
        end else if (accept) begin
          target_d = cmd_target;
          if (cmd_target != position_q) begin
            state_d = ST_MOVING;
            timer_d = TMR_RELOAD;
          end
        end
      end
      ST_MOVING: begin
        if (home_req) begin
          state_d    = ST_HOMING;
          home_cnt_d = '0;
          homed_d    = 1'b0;
        end else begin
          // new target only takes effect at the following tick
          if (accept) target_d = cmd_target;
          if (lim_s_q && (position_q > target_q)) begin
            position_d = '0;
            state_d    = ST_IDLE;
          end else if (tick) begin
            if (position_q < target_q) begin
              ph_d       = ph_q + 2'd1;
              position_d = position_q + POS_W'(1);
            end else if (position_q > target_q) begin
              ph_d       = ph_q - 2'd1;
              position_d = position_q - POS_W'(1);
            end else begin
              state_d = ST_IDLE;
            end
          end
        end
      end
      ST_HOMING: begin
        if (tick) begin
          if (lim_s_q) begin
            position_d = '0;
            homed_d    = 1'b1;
            state_d    = ST_IDLE;
          end else begin
            ph_d       = ph_q - 2'd1;
            home_cnt_d = home_cnt_q + HC_W'(1);
            if ((home_cnt_q + HC_W'(1)) == HC_MAX) begin
              state_d = ST_FAULT;
              fault_d = 1'b1;
              homed_d = 1'b0;
            end
          end
        end
      end
      default: begin
        if (home_req) begin
          state_d    = ST_HOMING;
          timer_d    = TMR_RELOAD;
          home_cnt_d = '0;
          fault_d    = 1'b0;
        end
      end
    endcase

    busy_d   = (state_d == ST_MOVING) || (state_d == ST_HOMING);
    drive_en = busy_d || (HOLD_EN && (state_d == ST_IDLE) && homed_d);
    enable_d = drive_en;
    coils_d  = drive_en ? phase_pattern(ph_d) : 4'b0000;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      ph_q       <= '0;
      position_q <= '0;
      target_q   <= '0;
      timer_q    <= '0;
      home_cnt_q <= '0;
      homed_q    <= 1'b0;
      fault_q    <= 1'b0;
      busy_q     <= 1'b0;
      enable_q   <= 1'b0;
      coils_q    <= 4'b0000;
      lim_meta_q <= 1'b0;
      lim_s_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      ph_q       <= ph_d;
      position_q <= position_d;
      target_q   <= target_d;
      timer_q    <= timer_d;
      home_cnt_q <= home_cnt_d;
      homed_q    <= homed_d;
      fault_q    <= fault_d;
      busy_q     <= busy_d;
      enable_q   <= enable_d;
      coils_q    <= coils_d;
      lim_meta_q <= limit_switch;
      lim_s_q    <= lim_meta_q;
    end
  end

  assign coils    = coils_q;
  assign enable   = enable_q;
  assign position = position_q;
  assign busy     = busy_q;
  assign homed    = homed_q;
  assign fault    = fault_q;

endmodule

// File: tb/tb_stepper_driver.sv
// Scoreboard bench for stepper_driver: stimulus queues expected output snapshots,
// a monitor pops one per observed output change and checks value and spacing.
module tb_stepper_driver;
  localparam int STEP_DIV = 4;
  localparam int POS_W    = 16;
  localparam int HOME_MAX = 8;

  logic             clock = 1'b0;
  logic             reset = 1'b0;
  logic             cmd_valid = 1'b0;
  logic [POS_W-1:0] cmd_target = '0;
  logic             cmd_ready;
  logic             home_req = 1'b0;
  logic             limit_switch = 1'b0;
  logic [3:0]       coils;
  logic             enable;
  logic [POS_W-1:0] position;
  logic             busy, homed, fault;

  stepper_driver #(.STEP_DIV(STEP_DIV), .POS_W(POS_W), .HOME_MAX_STEPS(HOME_MAX)) dut (
    .clock(clock), .reset(reset), .cmd_valid(cmd_valid), .cmd_target(cmd_target),
    .cmd_ready(cmd_ready), .home_req(home_req), .limit_switch(limit_switch),
    .coils(coils), .enable(enable), .position(position), .busy(busy),
    .homed(homed), .fault(fault)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [3:0]  coils;
    logic        enable;
    logic [15:0] position;
    logic        busy;
    logic        homed;
    logic        fault;
  } snap_t;

  typedef struct {
    snap_t s;
    int    gap;
    string name;
  } exp_t;

  exp_t       exp_q[$];
  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  logic       mon_en = 1'b0;
  logic [1:0] tb_ph = 2'd0;

  always @(posedge clock) cyc++;

  function automatic snap_t cur();
    snap_t s;
    s.coils = coils; s.enable = enable; s.position = position;
    s.busy = busy; s.homed = homed; s.fault = fault;
    return s;
  endfunction

  function automatic logic [3:0] pat(input logic [1:0] p);
    case (p)
      2'd0:    return 4'b1100;
      2'd1:    return 4'b0110;
      2'd2:    return 4'b0011;
      default: return 4'b1001;
    endcase
  endfunction

  function automatic snap_t mk(input logic [3:0] c, input logic en, input logic [15:0] pos,
                               input logic b, input logic h, input logic f);
    snap_t s;
    s.coils = c; s.enable = en; s.position = pos; s.busy = b; s.homed = h; s.fault = f;
    return s;
  endfunction

  // idle after a successful home
  function automatic snap_t idle_snap(input logic [1:0] p, input logic [15:0] pos);
`ifdef STEPPER_HOLD_EN
    return mk(pat(p), 1'b1, pos, 1'b0, 1'b1, 1'b0);
`else
    return mk(4'b0000, 1'b0, pos, 1'b0, 1'b1, 1'b0);
`endif
  endfunction

  task automatic push(input snap_t s, input int gap, input string name);
    exp_t e;
    e.s = s; e.gap = gap; e.name = name;
    exp_q.push_back(e);
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, got, want);
    end else begin
      $display("ok   %s: %h", name, got);
    end
  endtask

  task automatic clk(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic send_cmd(input logic [15:0] t, input logic want_rdy, input string nm);
    cmd_valid = 1'b1;
    cmd_target = t;
    #1 chk(nm, {31'd0, cmd_ready}, {31'd0, want_rdy});
    @(negedge clock);
    cmd_valid = 1'b0;
  endtask

  task automatic home_pulse();
    home_req = 1'b1;
    @(negedge clock);
    home_req = 1'b0;
  endtask

  task automatic move_to(input int from, input int to);
    int n;
    int p;
    n = (from < to) ? to - from : from - to;
    p = from;
    push(mk(pat(tb_ph), 1'b1, 16'(from), 1'b1, 1'b1, 1'b0), 0, "move_accept");
    for (int i = 0; i < n; i++) begin
      if (from < to) begin p++; tb_ph++; end
      else begin p--; tb_ph--; end
      push(mk(pat(tb_ph), 1'b1, 16'(p), 1'b1, 1'b1, 1'b0), STEP_DIV, "move_step");
    end
    push(idle_snap(tb_ph, 16'(p)), STEP_DIV, "move_done");
    send_cmd(16'(to), 1'b1, "ready_move");
    clk(STEP_DIV * (n + 1) + 3);
  endtask

  // monitor: every change of the registered outputs is one transaction
  initial begin
    snap_t prev, now;
    exp_t  e;
    int    last_cyc;
    wait (mon_en);
    prev = cur();
    last_cyc = cyc;
    forever begin
      @(negedge clock);
      now = cur();
      if (now !== prev) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_change: got %h, expected no change", now);
        end else begin
          e = exp_q.pop_front();
          if (now !== e.s || (e.gap != 0 && (cyc - last_cyc) != e.gap)) begin
            errors++;
            $display("FAIL %s: got %h gap %0d, expected %h gap %0d",
                     e.name, now, cyc - last_cyc, e.s, e.gap);
          end else begin
            $display("ok   %s: %h gap %0d", e.name, now, cyc - last_cyc);
          end
        end
        prev = now;
        last_cyc = cyc;
      end
    end
  end

  initial begin
    clk(3);
    chk("reset_outputs", {7'd0, cur()}, 32'd0);
    reset = 1'b1;
    clk(20);
    chk("idle_outputs", {7'd0, cur()}, 32'd0);
    mon_en = 1'b1;
    send_cmd(16'd5, 1'b0, "ready_unhomed");
    clk(10);
    chk("no_motion_unhomed", {16'd0, position}, 32'd0);

    // homing: three reverse steps, then the switch
    tb_ph = 2'd0;
    push(mk(pat(tb_ph), 1'b1, 16'd0, 1'b1, 1'b0, 1'b0), 0, "home_start");
    for (int i = 0; i < 3; i++) begin
      tb_ph--;
      push(mk(pat(tb_ph), 1'b1, 16'd0, 1'b1, 1'b0, 1'b0), STEP_DIV, "home_step");
    end
    push(idle_snap(tb_ph, 16'd0), STEP_DIV, "homed");
    home_pulse();
    clk(12);
    limit_switch = 1'b1;
    clk(4);
    limit_switch = 1'b0;
    clk(8);

    move_to(0, 5);
    move_to(5, 0);

    // toward 10, retarget to 2 once at 4
    push(mk(pat(tb_ph), 1'b1, 16'd0, 1'b1, 1'b1, 1'b0), 0, "retgt_accept");
    for (int p = 1; p <= 4; p++) begin
      tb_ph++;
      push(mk(pat(tb_ph), 1'b1, 16'(p), 1'b1, 1'b1, 1'b0), STEP_DIV, "retgt_fwd");
    end
    for (int p = 3; p >= 2; p--) begin
      tb_ph--;
      push(mk(pat(tb_ph), 1'b1, 16'(p), 1'b1, 1'b1, 1'b0), STEP_DIV, "retgt_rev");
    end
    push(idle_snap(tb_ph, 16'd2), STEP_DIV, "retgt_done");
    send_cmd(16'd10, 1'b1, "ready_move10");
    clk(16);
    send_cmd(16'd2, 1'b1, "ready_retarget");
    clk(14);

    // home_req and cmd_valid together: homing wins
    push(mk(pat(tb_ph), 1'b1, 16'd2, 1'b1, 1'b0, 1'b0), 0, "home_vs_cmd");
    push(idle_snap(tb_ph, 16'd0), STEP_DIV, "rehomed");
    home_req = 1'b1;
    cmd_valid = 1'b1;
    cmd_target = 16'd7;
    #1 chk("ready_home_vs_cmd", {31'd0, cmd_ready}, 32'd0);
    @(negedge clock);
    home_req = 1'b0;
    cmd_valid = 1'b0;
    limit_switch = 1'b1;
    clk(4);
    limit_switch = 1'b0;
    clk(8);

    // homing timeout
    push(mk(pat(tb_ph), 1'b1, 16'd0, 1'b1, 1'b0, 1'b0), 0, "fault_home_start");
    for (int i = 0; i < HOME_MAX - 1; i++) begin
      tb_ph--;
      push(mk(pat(tb_ph), 1'b1, 16'd0, 1'b1, 1'b0, 1'b0), STEP_DIV, "fault_home_step");
    end
    tb_ph--;
    push(mk(4'b0000, 1'b0, 16'd0, 1'b0, 1'b0, 1'b1), STEP_DIV, "fault");
    home_pulse();
    clk(STEP_DIV * HOME_MAX + 4);
    chk("ready_in_fault", {31'd0, cmd_ready}, 32'd0);

    // home_req leaves FAULT
    push(mk(pat(tb_ph), 1'b1, 16'd0, 1'b1, 1'b0, 1'b0), 0, "fault_clear");
    push(idle_snap(tb_ph, 16'd0), STEP_DIV, "homed_again");
    home_pulse();
    limit_switch = 1'b1;
    clk(4);
    limit_switch = 1'b0;
    clk(8);

    // asynchronous reset in the middle of a move
    push(mk(pat(tb_ph), 1'b1, 16'd0, 1'b1, 1'b1, 1'b0), 0, "mid_accept");
    tb_ph++;
    push(mk(pat(tb_ph), 1'b1, 16'd1, 1'b1, 1'b1, 1'b0), STEP_DIV, "mid_step");
    push(mk(4'b0000, 1'b0, 16'd0, 1'b0, 1'b0, 1'b0), 0, "async_reset");
    send_cmd(16'd3, 1'b1, "ready_mid");
    clk(5);
    #2 reset = 1'b0;
    #1 chk("reset_immediate", {7'd0, cur()}, 32'd0);
    clk(3);
    reset = 1'b1;
    clk(6);

    chk("scoreboard_drained", exp_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
